// File: rtl/vram_pkg.sv
// Shared VRAM types: address/data widths, grant kinds and read-return tags.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package vram_pkg;
  localparam int VRAM_ADDR_W = 13;
  localparam int VRAM_DATA_W = 32;

  typedef enum logic [1:0] {GNT_NONE, GNT_VGA, GNT_ENG, GNT_FORCE} gnt_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_ENG} tag_e;

  // Only reads produce return data; engine writes leave no tag behind.
  function automatic tag_e gnt_to_tag(gnt_e g, logic we);
    tag_e t;
    t = TAG_NONE;
    if (g == GNT_VGA) t = TAG_VGA;
    else if ((g == GNT_ENG || g == GNT_FORCE) && !we) t = TAG_ENG;
    return t;
  endfunction
endpackage

// File: rtl/vram_rd_return.sv
// Read-return path: tags each grant, then steers RAM_B doutb to the owning requester.
// Latency: data and valid strobe visible 2 cycles after the grant cycle.
// Backpressure: none; one return per cycle at most, always accepted.
module vram_rd_return
  import vram_pkg::*;
#(
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        tag_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] vga_data_o,
  output logic              vga_valid_o,
  output logic [DATA_W-1:0] eng_rdata_o,
  output logic              eng_rvalid_o
);
  tag_e              tag_s1_q;
  tag_e              tag_s2_q;
  logic [DATA_W-1:0] vga_data_q;
  logic [DATA_W-1:0] eng_rdata_q;

  // Shift the grant tag along and capture doutb for whoever owned the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_s1_q    <= TAG_NONE;
      tag_s2_q    <= TAG_NONE;
      vga_data_q  <= '0;
      eng_rdata_q <= '0;
    end else begin
      tag_s1_q <= tag_e'(tag_i);
      tag_s2_q <= tag_s1_q;
      if (tag_s1_q == TAG_VGA) vga_data_q  <= rdata_i;
      if (tag_s1_q == TAG_ENG) eng_rdata_q <= rdata_i;
    end
  end

  assign vga_data_o   = vga_data_q;
  assign eng_rdata_o  = eng_rdata_q;
  assign vga_valid_o  = (tag_s2_q == TAG_VGA);
  assign eng_rvalid_o = (tag_s2_q == TAG_ENG);
endmodule

// File: rtl/vram_port_arbiter.sv
// Shares RAM_B port B between VGA scan-out (priority) and the tile engine, with starvation forcing.
// Latency: grant is combinational; read data returns 2 cycles after the grant.
// Backpressure: engine holds eng_req until eng_gnt; VGA is never stalled but may be dropped (vga_miss).
// Optional: define VRAM_ARB_STATS_EN to add grant/miss statistics counters and stat_clr.
module vram_port_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W       = VRAM_ADDR_W,
  parameter int DATA_W       = VRAM_DATA_W,
  parameter int STARVE_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  output logic              vga_miss,
  input  logic              eng_req,
  input  logic              eng_we,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [DATA_W-1:0] eng_wdata,
  output logic              eng_gnt,
  output logic [DATA_W-1:0] eng_rdata,
  output logic              eng_rvalid,
  output logic [ADDR_W-1:0] ram_addrb,
  output logic              ram_web,
  output logic [DATA_W-1:0] ram_dinb,
  input  logic [DATA_W-1:0] ram_doutb,
`ifdef VRAM_ARB_STATS_EN
  input  logic              stat_clr,
  output logic [31:0]       stat_vga_cnt,
  output logic [31:0]       stat_eng_cnt,
  output logic [15:0]       stat_miss_cnt,
`endif
  output logic              starved
);
  localparam int             CNT_W    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(STARVE_LIMIT);
  localparam bit             FORCE_EN = (STARVE_LIMIT != 0);

  gnt_e              gnt;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              at_limit;

  assign at_limit = FORCE_EN && (wait_cnt_q == LIMIT);

  // Pick this cycle's owner; reset discards any pending request.
  always_comb begin
    gnt = GNT_NONE;
    if (rst)                    gnt = GNT_NONE;
    else if (eng_req && at_limit) gnt = GNT_FORCE;
    else if (vga_req)           gnt = GNT_VGA;
    else if (eng_req)           gnt = GNT_ENG;
  end

  // Steer the RAM port; the address holds across idle cycles to avoid toggling.
  always_comb begin
    ram_addrb = rst ? '0 : ram_addr_q;
    ram_web   = 1'b0;
    ram_dinb  = '0;
    eng_gnt   = 1'b0;
    case (gnt)
      GNT_VGA: ram_addrb = vga_addr;
      GNT_ENG, GNT_FORCE: begin
        ram_addrb = eng_addr;
        ram_web   = eng_we;
        ram_dinb  = eng_wdata;
        eng_gnt   = 1'b1;
      end
      default: ;
    endcase
  end

  assign vga_miss = (gnt == GNT_FORCE) && vga_req;
  assign starved  = !rst && at_limit;

  // Engine wait counter: counts ungranted request cycles, saturating at the limit.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!eng_req || eng_gnt)   wait_cnt_d = '0;
    else if (wait_cnt_q != LIMIT) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  // State registers for the wait counter and the held port address.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      ram_addr_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      ram_addr_q <= ram_addrb;
    end
  end

  vram_rd_return #(.DATA_W(DATA_W)) u_rd_return (
    .clk          (clk),
    .rst          (rst),
    .tag_i        (gnt_to_tag(gnt, eng_we)),
    .rdata_i      (ram_doutb),
    .vga_data_o   (vga_data),
    .vga_valid_o  (vga_valid),
    .eng_rdata_o  (eng_rdata),
    .eng_rvalid_o (eng_rvalid)
  );

`ifdef VRAM_ARB_STATS_EN
  logic [31:0] stat_vga_q, stat_eng_q;
  logic [15:0] stat_miss_q;

  // Free-running grant/miss counters; clear takes precedence over a same-cycle event.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_vga_q  <= '0;
      stat_eng_q  <= '0;
      stat_miss_q <= '0;
    end else begin
      if (gnt == GNT_VGA) stat_vga_q  <= stat_vga_q + 32'd1;
      if (eng_gnt)        stat_eng_q  <= stat_eng_q + 32'd1;
      if (vga_miss)       stat_miss_q <= stat_miss_q + 16'd1;
    end
  end

  assign stat_vga_cnt  = stat_vga_q;
  assign stat_eng_cnt  = stat_eng_q;
  assign stat_miss_cnt = stat_miss_q;
`endif
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: RAM_B model, behavioural scoreboard, directed + random stimulus.
module tb_vram_port_arbiter;
  localparam int LIM = 16;

  logic        clk;
  logic        rst;
  logic        vga_req;
  logic [12:0] vga_addr;
  logic        eng_req;
  logic        eng_we;
  logic [12:0] eng_addr;
  logic [31:0] eng_wdata;
  logic        stat_clr;

  logic [31:0] vga_data, eng_rdata, ram_dinb;
  logic        vga_valid, vga_miss, eng_gnt, eng_rvalid, ram_web, starved;
  logic [12:0] ram_addrb;
  logic [31:0] ram_doutb;

  logic [31:0] u1_vga_data, u1_eng_rdata, u1_ram_dinb;
  logic        u1_vga_valid, u1_vga_miss, u1_eng_gnt, u1_eng_rvalid, u1_ram_web, u1_starved;
  logic [12:0] u1_ram_addrb;
  logic [31:0] u1_ram_doutb;

`ifdef VRAM_ARB_STATS_EN
  logic [31:0] stat_vga_cnt, stat_eng_cnt, u1_stat_vga, u1_stat_eng;
  logic [15:0] stat_miss_cnt, u1_stat_miss;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  bit [31:0] ram_mem [8192];
  bit [31:0] exp_mem [8192];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vram_port_arbiter #(.ADDR_W(13), .DATA_W(32), .STARVE_LIMIT(LIM)) u0 (
    .clk(clk), .rst(rst), .vga_req(vga_req), .vga_addr(vga_addr),
    .vga_data(vga_data), .vga_valid(vga_valid), .vga_miss(vga_miss),
    .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
    .eng_gnt(eng_gnt), .eng_rdata(eng_rdata), .eng_rvalid(eng_rvalid),
    .ram_addrb(ram_addrb), .ram_web(ram_web), .ram_dinb(ram_dinb), .ram_doutb(ram_doutb),
`ifdef VRAM_ARB_STATS_EN
    .stat_clr(stat_clr), .stat_vga_cnt(stat_vga_cnt), .stat_eng_cnt(stat_eng_cnt),
    .stat_miss_cnt(stat_miss_cnt),
`endif
    .starved(starved)
  );

  vram_port_arbiter #(.ADDR_W(13), .DATA_W(32), .STARVE_LIMIT(0)) u1 (
    .clk(clk), .rst(rst), .vga_req(vga_req), .vga_addr(vga_addr),
    .vga_data(u1_vga_data), .vga_valid(u1_vga_valid), .vga_miss(u1_vga_miss),
    .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
    .eng_gnt(u1_eng_gnt), .eng_rdata(u1_eng_rdata), .eng_rvalid(u1_eng_rvalid),
    .ram_addrb(u1_ram_addrb), .ram_web(u1_ram_web), .ram_dinb(u1_ram_dinb),
    .ram_doutb(u1_ram_doutb),
`ifdef VRAM_ARB_STATS_EN
    .stat_clr(stat_clr), .stat_vga_cnt(u1_stat_vga), .stat_eng_cnt(u1_stat_eng),
    .stat_miss_cnt(u1_stat_miss),
`endif
    .starved(u1_starved)
  );

  assign u1_ram_doutb = 32'h0;

  // RAM_B port B model: write-first, 1-cycle registered read.
  always @(posedge clk) begin
    if (ram_web) ram_mem[ram_addrb] <= ram_dinb;
    ram_doutb <= ram_web ? ram_dinb : ram_mem[ram_addrb];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural scoreboard ----------------
  typedef struct {
    int        due;
    bit        is_vga;
    bit [31:0] dat;
  } ret_t;

  ret_t        rq[$];
  int          cyc = 0;
  int          m_wait = 0;
  logic [12:0] m_last = '0;
  logic [31:0] m_vdat = '0, m_edat = '0;
  logic [31:0] m_sv = '0, m_se = '0;
  logic [15:0] m_sm = '0;

  always @(negedge clk) begin
    bit forced, to_vga, to_eng, exp_v, exp_e;
    logic [12:0] a;
    cyc++;
    if (rst) begin
      chk("rst_eng_gnt", eng_gnt, 0);
      chk("rst_web", ram_web, 0);
      chk("rst_addrb", ram_addrb, 0);
      chk("rst_dinb", ram_dinb, 0);
      chk("rst_miss", vga_miss, 0);
      chk("rst_starved", starved, 0);
      chk("rst_u1_gnt", u1_eng_gnt, 0);
      rq.delete();
      m_wait = 0; m_last = '0; m_vdat = '0; m_edat = '0;
      m_sv = '0; m_se = '0; m_sm = '0;
    end else begin
      exp_v = 0; exp_e = 0;
      while (rq.size() > 0 && rq[0].due <= cyc) begin
        if (rq[0].is_vga) begin exp_v = 1; m_vdat = rq[0].dat; end
        else begin exp_e = 1; m_edat = rq[0].dat; end
        void'(rq.pop_front());
      end
      chk("vga_valid", vga_valid, exp_v);
      chk("vga_data", vga_data, m_vdat);
      chk("eng_rvalid", eng_rvalid, exp_e);
      chk("eng_rdata", eng_rdata, m_edat);
`ifdef VRAM_ARB_STATS_EN
      chk("stat_vga", stat_vga_cnt, m_sv);
      chk("stat_eng", stat_eng_cnt, m_se);
      chk("stat_miss", stat_miss_cnt, m_sm);
`endif
      forced = eng_req && (m_wait == LIM);
      to_eng = forced || (eng_req && !vga_req);
      to_vga = vga_req && !forced;
      a = to_vga ? vga_addr : (to_eng ? eng_addr : m_last);
      chk("eng_gnt", eng_gnt, to_eng);
      chk("ram_addrb", ram_addrb, a);
      chk("ram_web", ram_web, to_eng && eng_we);
      if (to_eng && eng_we) chk("ram_dinb", ram_dinb, eng_wdata);
      chk("vga_miss", vga_miss, forced && vga_req);
      chk("starved", starved, m_wait == LIM);
      // Zero-limit instance: plain VGA priority, never forced.
      chk("u1_eng_gnt", u1_eng_gnt, eng_req && !vga_req);
      chk("u1_starved", u1_starved, 0);
      chk("u1_miss", u1_vga_miss, 0);
      if (to_vga) rq.push_back('{cyc + 2, 1'b1, exp_mem[a]});
      if (to_eng && !eng_we) rq.push_back('{cyc + 2, 1'b0, exp_mem[a]});
      if (to_eng && eng_we) exp_mem[a] = eng_wdata;
      m_last = a;
      if (!eng_req || to_eng) m_wait = 0;
      else if (m_wait < LIM) m_wait++;
      if (stat_clr) begin
        m_sv = '0; m_se = '0; m_sm = '0;
      end else begin
        if (to_vga) m_sv++;
        if (to_eng) m_se++;
        if (forced && vga_req) m_sm++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first_starved, misses, g0, g1, mode, prob;
    bit g, r;
    logic [31:0] v;
    rst = 1; vga_req = 0; vga_addr = '0; eng_req = 0; eng_we = 0;
    eng_addr = '0; eng_wdata = '0; stat_clr = 0;
    repeat (3) tick;
    rst = 0;
    @(negedge clk);
    chk("post_rst_vga_valid", vga_valid, 0);
    chk("post_rst_eng_rvalid", eng_rvalid, 0);
    chk("post_rst_starved", starved, 0);

    // Engine write then read of 0x005, no VGA traffic.
    tick;
    eng_req = 1; eng_we = 1; eng_addr = 13'h005; eng_wdata = 32'hDEADBEEF;
    @(negedge clk) chk("lit_wr_gnt", eng_gnt, 1);
    tick;
    eng_we = 0;
    @(negedge clk);
    chk("lit_rd_gnt", eng_gnt, 1);
    chk("lit_rd_addr", ram_addrb, 13'h005);
    chk("lit_rd_web", ram_web, 0);
    tick;
    eng_req = 0;
    @(negedge clk) chk("lit_rvalid_n1", eng_rvalid, 0);
    tick;
    @(negedge clk);
    chk("lit_rvalid_n2", eng_rvalid, 1);
    chk("lit_rdata", eng_rdata, 32'hDEADBEEF);

    // Simultaneous VGA read and engine write: VGA first.
    tick;
    vga_req = 1; vga_addr = 13'h100;
    eng_req = 1; eng_we = 1; eng_addr = 13'h010; eng_wdata = 32'h1234;
    @(negedge clk);
    chk("lit_vga_wins", eng_gnt, 0);
    chk("lit_vga_addr", ram_addrb, 13'h100);
    tick;
    vga_req = 0;
    @(negedge clk);
    chk("lit_eng_next", eng_gnt, 1);
    tick;
    eng_req = 0;
    repeat (3) tick;
    v = ram_mem[16];
    chk("lit_ram_0x010", v, 32'h1234);

    // Starvation: VGA and an engine read both held for 40 cycles.
    first_starved = -1; misses = 0; g0 = 0; g1 = 0;
    vga_req = 1; eng_req = 1; eng_we = 0; eng_addr = 13'h020;
    for (int i = 0; i < 40; i++) begin
      vga_addr = 13'($urandom_range(0, 8191));
      @(negedge clk);
      if (starved && first_starved < 0) first_starved = i;
      if (vga_miss) misses++;
      if (eng_gnt) g0++;
      if (u1_eng_gnt) g1++;
      tick;
    end
    vga_req = 0; eng_req = 0;
    chk("lit_first_starved", first_starved, 16);
    chk("lit_miss_count", misses, 2);
    chk("lit_forced_grants", g0, 2);
    chk("lit_u1_no_grant", g1, 0);
    repeat (3) tick;

    // Reset one cycle after a VGA read grant: no return may appear.
    vga_req = 1; vga_addr = 13'h030;
    tick;
    vga_req = 0; rst = 1;
    tick;
    rst = 0;
    @(negedge clk);
    chk("lit_flush_valid", vga_valid, 0);
    chk("lit_flush_data", vga_data, 0);
    chk("lit_flush_addrb", ram_addrb, 0);
    chk("lit_flush_rdata", eng_rdata, 0);
    tick;
    @(negedge clk) chk("lit_flush_valid2", vga_valid, 0);
    tick;

    // Randomized traffic with varying VGA load and occasional reset/clear.
    mode = 0; prob = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 50 == 0) begin
        mode = $urandom_range(0, 3);
        prob = (mode == 0) ? 0 : (mode == 1) ? 50 : (mode == 2) ? 95 : 100;
      end
      @(negedge clk);
      g = eng_gnt; r = rst;
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 299) == 0);
      stat_clr = ($urandom_range(0, 199) == 0);
      vga_req = ($urandom_range(0, 99) < prob);
      vga_addr = 13'($urandom_range(0, 31));
      if (!eng_req || g || r) begin
        eng_req = ($urandom_range(0, 3) != 0);
        eng_we = $urandom_range(0, 1) == 1;
        eng_addr = 13'($urandom_range(0, 31));
        eng_wdata = $urandom;
      end
    end
    rst = 0; vga_req = 0; eng_req = 0; stat_clr = 0;
    repeat (4) tick;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
